// File: rtl/blink_multi.sv
// blink_multi: multi-channel active-low LED driver (off / on / blink / PWM per channel).
// Latency: led and pwm_wrap are registered; the state before the edge decides each new value.
// Backpressure: none. Duty writes are accepted every cycle; an out-of-range wr_ch is dropped.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   mode      per-channel mode, channel i at [2i+1:2i]: 00 off, 01 on, 10 blink, 11 pwm
//   wr_en     one-cycle duty write strobe
//   wr_ch     channel index for the duty write (ignored when >= CH)
//   wr_duty   duty value, W bits
//   led       LED pins, active-low (0 = lit)
//   pwm_wrap  one-cycle pulse in the cycle the PWM counter holds 0
//
// Build option: define BLINK_MULTI_PHASE_EN to give odd-index blink channels the inverted
// phase, so adjacent channels alternate.
module blink_multi #(
  parameter int CH   = 3,
  parameter int CDIV = 3,
  parameter int W    = 4,
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1,
  localparam int PW  = $clog2(CDIV + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*CH-1:0]   mode,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_ch,
  input  logic [W-1:0]      wr_duty,
  output logic [CH-1:0]     led,
  output logic              pwm_wrap
);

  logic [PW-1:0] pre;
  logic          phase;
  logic [W-1:0]  cnt;
  logic [W-1:0]  pend [CH];
  logic [W-1:0]  act  [CH];

  logic          pre_tick;
  logic          phase_nxt;
  logic          wrap;
  logic          wr_ok;
  logic [CH-1:0] lit;

  always_comb begin
    pre_tick  = (pre == PW'(CDIV));
    // Blink output follows the phase as it is after this edge, so a tick shows on led
    // in the same edge that toggles the phase.
    phase_nxt = phase ^ pre_tick;
    wrap      = (cnt == {W{1'b1}});
    wr_ok     = wr_en && ({1'b0, wr_ch} < (CHW + 1)'(CH));
    lit       = '0;
    for (int i = 0; i < CH; i++) begin
      case (mode[2*i +: 2])
        2'b00: lit[i] = 1'b0;
        2'b01: lit[i] = 1'b1;
`ifdef BLINK_MULTI_PHASE_EN
        2'b10: lit[i] = phase_nxt ^ ((i % 2) == 1);
`else
        2'b10: lit[i] = phase_nxt;
`endif
        default: lit[i] = (cnt < act[i]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre      <= '0;
      phase    <= 1'b0;
      cnt      <= '0;
      pwm_wrap <= 1'b0;
      led      <= '1;
      for (int i = 0; i < CH; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      pre      <= pre_tick ? PW'(1) : pre + PW'(1);
      phase    <= phase_nxt;
      cnt      <= cnt + W'(1);
      pwm_wrap <= wrap;
      led      <= ~lit;
      // Active duties only change at the wrap edge so a period never mixes two duties.
      // A write in the wrap cycle lands in pending after the copy has taken the old value.
      if (wrap) begin
        for (int i = 0; i < CH; i++) begin
          act[i] <= pend[i];
        end
      end
      if (wr_ok) begin
        pend[wr_ch] <= wr_duty;
      end
    end
  end

endmodule

// File: tb/tb_blink_multi.sv
// tb_blink_multi: directed self-checking bench for blink_multi (CH=3, CDIV=3, W=4).
// Covers reset, blink timing, PWM duty/boundaries, write-at-wrap timing, invalid channel
// writes, static modes, mode switching and mid-pattern reset.
module tb_blink_multi;

  localparam int CH   = 3;
  localparam int CDIV = 3;
  localparam int W    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] mode;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [3:0] wr_duty;
  logic [2:0] led;
  logic       pwm_wrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blink_multi #(.CH(CH), .CDIV(CDIV), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_duty  (wr_duty),
    .led      (led),
    .pwm_wrap (pwm_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef BLINK_MULTI_PHASE_EN
  logic [2:0] blink_exp [7] = '{3'b101, 3'b101, 3'b101, 3'b010, 3'b010, 3'b010, 3'b101};
`else
  logic [2:0] blink_exp [7] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111};
`endif

  initial begin
    logic [2:0] lit;
    logic [2:0] exp3;
    int c, d0, d2;

    rst = 1'b1; mode = 6'b111111; wr_en = 1'b0; wr_ch = 2'd0; wr_duty = 4'd0;

    // Reset: one edge, then a second edge with a write attempt that must be ignored.
    tick;
    check("reset_led", led, 3'b111);
    check("reset_wrap", pwm_wrap, 1'b0);
    wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd9;
    tick;
    check("reset_hold_led", led, 3'b111);
    check("reset_hold_wrap", pwm_wrap, 1'b0);
    wr_en = 1'b0;

    // Blink, all channels.
    mode = 6'b101010;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      check($sformatf("blink_e%0d", k + 1), led, blink_exp[k]);
    end

    // PWM: fresh reset, then edges numbered n = 1.. after release.
    rst = 1'b1; mode = 6'b111111;
    tick;
    rst = 1'b0;
    for (int n = 1; n <= 128; n++) begin
      case (n)
        1:   begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd5;  end
        2:   begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 4'd9;  end
        3:   begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 4'd0;  end
        4:   begin wr_en = 1'b1; wr_ch = 2'd2; wr_duty = 4'd15; end
        5:   wr_en = 1'b0;
        64:  begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd8;  end
        65:  wr_en = 1'b0;
        70:  begin wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 4'd3;  end
        71:  wr_en = 1'b0;
        100: mode = 6'b110101;
        104: mode = 6'b110011;
        default: ;
      endcase
      tick;
      c  = (n - 1) % 16;
      d0 = (n <= 16) ? 0 : ((n <= 80) ? 5 : 8);
      d2 = (n <= 16) ? 0 : 15;
      lit[0] = (n >= 100 && n <= 103) ? 1'b1 : (c < d0);
      lit[1] = (n >= 100 && n <= 103);
      lit[2] = (c < d2);
      exp3 = ~lit;
      check($sformatf("pwm_led_n%0d", n), led, exp3);
      check($sformatf("pwm_wrap_n%0d", n), pwm_wrap, (n % 16) == 0);
    end

    // Reset mid-pattern with a write pending: everything returns to the reset state.
    rst = 1'b1; mode = 6'b010101; wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd7;
    tick;
    check("midrst_led", led, 3'b111);
    check("midrst_wrap", pwm_wrap, 1'b0);
    rst = 1'b0; wr_en = 1'b0; mode = 6'b111111;
    for (int k = 1; k <= 20; k++) begin
      tick;
      check($sformatf("postrst_led_k%0d", k), led, 3'b111);
      check($sformatf("postrst_wrap_k%0d", k), pwm_wrap, k == 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
